// File: rtl/counter_down.sv
// Countdown timer with alarm.
// A synchronized button press loads a 4-bit start value, which then counts
// down once per TICK_DIV cycles. Reaching zero plays a square-wave tone for
// BEEP_TICKS tick periods, after which the block returns to idle.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a press; led holds last value, buzzer silent
// COUNT | led decrements once per tick period
// ALARM | led at zero, buzzer toggles every TONE_DIV cycles
module counter_down #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int TONE_DIV   = 25_000,
    parameter int BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press,
    input  logic [3:0] load_val,
    output logic [3:0] led,
    output logic       sound,
    output logic       busy,
    output logic       done
);

    localparam int BEEP_TOTAL = BEEP_TICKS * TICK_DIV;
    localparam int TICK_W = ($clog2(TICK_DIV)   < 1) ? 1 : $clog2(TICK_DIV);
    localparam int TONE_W = ($clog2(TONE_DIV)   < 1) ? 1 : $clog2(TONE_DIV);
    localparam int BEEP_W = ($clog2(BEEP_TOTAL) < 1) ? 1 : $clog2(BEEP_TOTAL);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ALARM = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic p1, p2, p3;
    logic rise;

    logic [TICK_W-1:0] tick_q;
    logic [TONE_W-1:0] tone_q;
    logic [BEEP_W-1:0] beep_q;

    logic tick_wrap, tone_wrap, beep_last;
    logic load_now, dec_now, zero_hit, alarm_end;

    // Three-flop button synchronizer; a load event is the first synchronized high cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
            p3 <= 1'b0;
        end else begin
            p1 <= press;
            p2 <= p1;
            p3 <= p2;
        end
    end

    assign rise = p2 & ~p3;

    assign tick_wrap = (tick_q == TICK_LAST);
    assign tone_wrap = (tone_q == TONE_LAST);
    assign beep_last = (beep_q == BEEP_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a press outranks every timer event in the same cycle.
    always_comb begin
        state_d   = state_q;
        load_now  = 1'b0;
        dec_now   = 1'b0;
        zero_hit  = 1'b0;
        alarm_end = 1'b0;
        if (rise) begin
            load_now = 1'b1;
            state_d  = (load_val != 4'd0) ? COUNT : ALARM;
        end else begin
            case (state_q)
                COUNT: begin
                    // led is never zero here, but the guard keeps it from wrapping.
                    if (tick_wrap && (led != 4'd0)) begin
                        dec_now = 1'b1;
                        if (led == 4'd1) begin
                            zero_hit = 1'b1;
                            state_d  = ALARM;
                        end
                    end
                end
                ALARM: begin
                    if (beep_last) begin
                        alarm_end = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Tick divider runs only while counting and restarts on every load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else if (load_now) begin
            tick_q <= '0;
        end else if (state_q == COUNT) begin
            tick_q <= tick_wrap ? '0 : tick_q + TICK_W'(1);
        end else begin
            tick_q <= '0;
        end
    end

    // Tone half-period and alarm duration counters, both cleared on alarm entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_q <= '0;
            beep_q <= '0;
        end else if (load_now || zero_hit) begin
            tone_q <= '0;
            beep_q <= '0;
        end else if (state_q == ALARM) begin
            tone_q <= tone_wrap ? '0 : tone_q + TONE_W'(1);
            beep_q <= beep_last ? '0 : beep_q + BEEP_W'(1);
        end else begin
            tone_q <= '0;
            beep_q <= '0;
        end
    end

    // Displayed count: loaded on press, decremented on each tick wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 4'd0;
        end else if (load_now) begin
            led <= load_val;
        end else if (dec_now) begin
            led <= led - 4'd1;
        end
    end

    // Buzzer square wave; forced low outside the alarm and on its last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sound <= 1'b0;
        end else if (load_now || zero_hit || alarm_end) begin
            sound <= 1'b0;
        end else if (state_q == ALARM) begin
            if (tone_wrap) begin
                sound <= ~sound;
            end
        end else begin
            sound <= 1'b0;
        end
    end

    // Single-cycle pulse whenever the alarm starts, whether by counting down or a zero load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (load_now && (load_val == 4'd0)) || zero_hit;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_counter_down.sv
module tb_counter_down;

    logic       clk;
    logic       rst;
    logic       press;
    logic [3:0] load_val;
    logic [3:0] led;
    logic       sound;
    logic       busy;
    logic       done;

    counter_down #(
        .TICK_DIV  (4),
        .TONE_DIV  (2),
        .BEEP_TICKS(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .press   (press),
        .load_val(load_val),
        .led     (led),
        .sound   (sound),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       press;
        logic [3:0] load_val;
        logic [3:0] led;
        logic       sound;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int passed = 0;

    function automatic void add(input logic p, input logic [3:0] lv, input logic [3:0] l,
                                input logic s, input logic b, input logic d);
        vec_t v;
        v.press = p; v.load_val = lv; v.led = l; v.sound = s; v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got led=%0d sound=%0b busy=%0b done=%0b, want led=%0d sound=%0b busy=%0b done=%0b",
                     name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [6:0] outs();
        return {led, sound, busy, done};
    endfunction

    initial begin
        logic [6:0] e;

        // Scenario A: load 3, count down, full alarm (entries are states after edge 1..24)
        add(1, 3, 0, 0, 0, 0); add(1, 3, 0, 0, 0, 0); add(1, 3, 3, 0, 1, 0);
        add(0, 7, 3, 0, 1, 0); add(0, 7, 3, 0, 1, 0); add(0, 7, 3, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 7, 2, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 7, 1, 0, 1, 0);
        add(0, 7, 0, 0, 1, 1); add(0, 7, 0, 0, 1, 0);
        add(0, 7, 0, 1, 1, 0); add(0, 7, 0, 1, 1, 0);
        add(0, 7, 0, 0, 1, 0); add(0, 7, 0, 0, 1, 0);
        add(0, 7, 0, 1, 1, 0); add(0, 7, 0, 1, 1, 0);
        add(0, 7, 0, 0, 0, 0); add(0, 7, 0, 0, 0, 0);
        // Scenario B: load 0 goes straight to alarm with a done pulse
        add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 1, 1);
        add(0, 5, 0, 0, 1, 0); add(0, 5, 0, 1, 1, 0); add(0, 5, 0, 1, 1, 0);
        add(0, 5, 0, 0, 1, 0); add(0, 5, 0, 0, 1, 0); add(0, 5, 0, 1, 1, 0);
        add(0, 5, 0, 1, 1, 0); add(0, 5, 0, 0, 0, 0); add(0, 5, 0, 0, 0, 0);
        // Scenario C: load 5, re-press with 9 while led=3
        add(1, 5, 0, 0, 0, 0); add(1, 5, 0, 0, 0, 0); add(1, 5, 5, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 9, 5, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 9, 4, 0, 1, 0);
        add(0, 9, 3, 0, 1, 0); add(1, 9, 3, 0, 1, 0); add(1, 9, 3, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 9, 9, 0, 1, 0);
        add(0, 9, 8, 0, 1, 0); add(0, 9, 8, 0, 1, 0);

        rst = 1'b1;
        press = 1'b0;
        load_val = 4'd0;
        @(negedge clk);
        chk("reset_state", outs(), 7'b0000_000);
        step();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            press    = vecs[i].press;
            load_val = vecs[i].load_val;
            step();
            chk($sformatf("vec%0d", i), outs(), {vecs[i].led, vecs[i].sound, vecs[i].busy, vecs[i].done});
        end

        // Asynchronous reset mid-count takes effect before the next edge
        #2 rst = 1'b1;
        #1 chk("rst_mid_count", outs(), 7'b0000_000);
        press = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Press held for 20 cycles with load 2 is a single load
        load_val = 4'd2;
        for (int k = 1; k <= 24; k++) begin
            press = (k <= 20);
            step();
            e[6:3] = (k < 3) ? 4'd0 : (k < 7) ? 4'd2 : (k < 11) ? 4'd1 : 4'd0;
            e[2]   = (k == 13 || k == 14 || k == 17 || k == 18);
            e[1]   = (k >= 3 && k <= 18);
            e[0]   = (k == 11);
            chk($sformatf("held_k%0d", k), outs(), e);
        end

        // Load 1, then reset asynchronously while the buzzer is high
        press = 1'b0;
        step(); step();
        load_val = 4'd1;
        for (int k = 1; k <= 9; k++) begin
            press = (k <= 3);
            step();
            if (k == 3) chk("e_load1", outs(), {4'd1, 1'b0, 1'b1, 1'b0});
            if (k == 7) chk("e_zero", outs(), {4'd0, 1'b0, 1'b1, 1'b1});
        end
        chk("e_sound_high", outs(), {4'd0, 1'b1, 1'b1, 1'b0});
        #2 rst = 1'b1;
        #1 chk("rst_mid_alarm", outs(), 7'b0000_000);
        press = 1'b1;
        load_val = 4'd1;
        @(negedge clk);
        rst = 1'b0;

        // Press held through reset release counts as one press
        for (int k = 1; k <= 10; k++) begin
            step();
            e[6:3] = (k >= 3 && k < 7) ? 4'd1 : 4'd0;
            e[2]   = (k == 9 || k == 10);
            e[1]   = (k >= 3);
            e[0]   = (k == 7);
            chk($sformatf("post_rst_k%0d", k), outs(), e);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
